// File: rtl/imm_encoder.sv
// RV32I instruction packer: range-checks the immediate for the chosen format,
// packs the word and queues it in a small valid/ready FIFO with usage counters.
module imm_encoder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_type,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [7:0]       err_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_L, FMT_BAD
  } fmt_e;

  logic        imm_ok;
  logic [31:0] imm_q;
  logic [31:0] enc_instr;

  // A value fits in N signed bits when every bit above bit N-1 equals the sign bit.
  always_comb begin
    imm_ok = 1'b1;
    case (fmt_e'(in_type))
      FMT_I, FMT_S, FMT_L: imm_ok = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
      FMT_B:   imm_ok = ((in_imm[31:12] == '0) || (in_imm[31:12] == '1)) && !in_imm[0];
      FMT_J:   imm_ok = ((in_imm[31:20] == '0) || (in_imm[31:20] == '1)) && !in_imm[0];
      FMT_U:   imm_ok = (in_imm[11:0] == '0);
      FMT_R:   imm_ok = 1'b1;
      default: imm_ok = 1'b0;
    endcase
  end

  assign imm_q = imm_ok ? in_imm : '0;

  always_comb begin
    enc_instr = '0;
    case (fmt_e'(in_type))
      FMT_R: enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
      FMT_I: enc_instr = {imm_q[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
      FMT_L: enc_instr = {imm_q[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
      FMT_S: enc_instr = {imm_q[11:5], in_rs2, in_rs1, in_funct3, imm_q[4:0], 7'b0100011};
      FMT_B: enc_instr = {imm_q[12], imm_q[10:5], in_rs2, in_rs1, in_funct3,
                          imm_q[4:1], imm_q[11], 7'b1100011};
      FMT_U: enc_instr = {imm_q[31:12], in_rd, 7'b0110111};
      FMT_J: enc_instr = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], in_rd, 7'b1101111};
      default: enc_instr = '0;
    endcase
  end

  logic [31:0]    mem_instr [DEPTH];
  logic           mem_err   [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic           push;
  logic           pop;

  // in_ready depends only on the registered occupancy, never on out_ready.
  assign in_ready  = (count != CNT_FULL);
  assign out_valid = (count != '0);
  assign out_instr = mem_instr[rd_ptr];
  assign out_err   = mem_err[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_err[i]   <= 1'b0;
      end
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      enc_count <= '0;
      err_count <= '0;
    end else begin
      if (push) begin
        mem_instr[wr_ptr] <= enc_instr;
        mem_err[wr_ptr]   <= !imm_ok;
        wr_ptr            <= wr_ptr + PTR_W'(1);
        enc_count         <= enc_count + CNT_W'(1);
        if (!imm_ok && (err_count != 8'hFF))
          err_count <= err_count + 8'd1;
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed test-plan steps plus randomized traffic for imm_encoder, checked
// against an arithmetic reference encoder and a queue scoreboard.
module tb_imm_encoder;

  localparam int DEPTH = 2;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_type = '0;
  logic [4:0]       in_rd = '0;
  logic [4:0]       in_rs1 = '0;
  logic [4:0]       in_rs2 = '0;
  logic [2:0]       in_funct3 = '0;
  logic [6:0]       in_funct7 = '0;
  logic [31:0]      in_imm = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_instr;
  logic             out_err;
  logic [CNT_W-1:0] enc_count;
  logic [7:0]       err_count;

  always #5 clk = ~clk;

  imm_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count)
  );

  int n_assert = 0;
  int n_fail = 0;
  logic [32:0] sb [$];
  int enc_m = 0;
  int err_m = 0;
  int bnd [16] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095,
                   4096, -1048577, -1048576, 1048574, 1048575, 1048576, 0, 1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: range rules by signed arithmetic, packing straight from the field layout.
  function automatic logic [32:0] ref_enc(input logic [2:0] t, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm);
    int s;
    logic bad;
    logic [31:0] m;
    logic [31:0] w;
    s = $signed(imm);
    case (t)
      3'd1, 3'd2, 3'd6: bad = (s < -2048) || (s > 2047);
      3'd3:    bad = (s < -4096) || (s > 4094) || (s % 2 != 0);
      3'd5:    bad = (s < -1048576) || (s > 1048574) || (s % 2 != 0);
      3'd4:    bad = (imm % 4096) != 0;
      3'd0:    bad = 1'b0;
      default: bad = 1'b1;
    endcase
    m = bad ? 32'd0 : imm;
    case (t)
      3'd0: w = {f7, rs2, rs1, f3, rd, 7'b0110011};
      3'd1: w = {m[11:0], rs1, f3, rd, 7'b0010011};
      3'd2: w = {m[11:5], rs2, rs1, f3, m[4:0], 7'b0100011};
      3'd3: w = {m[12], m[10:5], rs2, rs1, f3, m[4:1], m[11], 7'b1100011};
      3'd4: w = {m[31:12], rd, 7'b0110111};
      3'd5: w = {m[20], m[10:1], m[11], m[19:12], rd, 7'b1101111};
      3'd6: w = {m[11:0], rs1, f3, rd, 7'b0000011};
      default: w = 32'd0;
    endcase
    return {bad, w};
  endfunction

  // One clock: check visible state, predict the handshake, advance, check counters.
  task automatic cycle();
    logic acc;
    logic pop;
    logic [32:0] e;
    check("in_ready", 32'(in_ready), 32'(sb.size() < DEPTH));
    check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      check("out_instr", out_instr, sb[0][31:0]);
      check("out_err", 32'(out_err), 32'(sb[0][32]));
    end
    acc = in_valid && (sb.size() < DEPTH);
    pop = out_ready && (sb.size() != 0);
    e = ref_enc(in_type, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
    @(posedge clk);
    if (pop) void'(sb.pop_front());
    if (acc) begin
      sb.push_back(e);
      enc_m = (enc_m + 1) % (1 << CNT_W);
      if (e[32] && err_m < 255) err_m++;
    end
    @(negedge clk);
    check("enc_count", 32'(enc_count), 32'(enc_m));
    check("err_count", 32'(err_count), 32'(err_m));
  endtask

  task automatic set_fields(input int t, input int rd, input int rs1, input int rs2,
      input int f3, input int f7, input int imm);
    in_type = 3'(t); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
    in_funct3 = 3'(f3); in_funct7 = 7'(f7); in_imm = 32'(imm);
  endtask

  task automatic send(input int t, input int rd, input int rs1, input int rs2,
      input int f3, input int f7, input int imm);
    set_fields(t, rd, rs1, rs2, f3, f7, imm);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    enc_m = 0;
    err_m = 0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_enc_count", 32'(enc_count), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
  endtask

  function automatic int rand_imm();
    case ($urandom_range(0, 4))
      0: return int'($urandom_range(0, 12000)) - 6000;
      1: return int'($urandom_range(0, 4200000)) - 2100000;
      2: return int'($urandom & 32'hFFFFF000);
      3: return int'($urandom);
      default: return bnd[$urandom_range(0, 15)];
    endcase
  endfunction

  logic [31:0] held;

  initial begin
    @(negedge clk);
    do_reset();

    out_ready = 1'b1;
    send(1, 1, 0, 0, 0, 0, -5);
    check("tp_i_instr", out_instr, 32'hFFB00093);
    check("tp_i_err", 32'(out_err), 32'd0);
    check("tp_i_enc", 32'(enc_count), 32'd1);
    send(2, 0, 1, 2, 2, 0, 8);
    check("tp_s_instr", out_instr, 32'h0020A423);
    send(3, 0, 0, 0, 0, 0, -4);
    check("tp_b_instr", out_instr, 32'hFE000EE3);
    send(1, 1, 0, 0, 0, 0, 2048);
    check("tp_i_range_instr", out_instr, 32'h00000093);
    check("tp_i_range_err", 32'(out_err), 32'd1);
    check("tp_i_range_cnt", 32'(err_count), 32'd1);
    send(3, 0, 0, 0, 0, 0, 3);
    check("tp_b_odd_err", 32'(out_err), 32'd1);
    send(4, 5, 0, 0, 0, 0, 32'h12345000);
    check("tp_u_instr", out_instr, 32'h123452B7);
    check("tp_u_err", 32'(out_err), 32'd0);
    cycle();

    // Backpressure: two fill the FIFO, the third waits for the first pop.
    do_reset();
    out_ready = 1'b0;
    send(1, 3, 4, 0, 0, 0, 100);
    held = out_instr;
    send(2, 0, 5, 6, 2, 0, -100);
    check("bp_in_ready_full", 32'(in_ready), 32'd0);
    set_fields(5, 7, 0, 0, 0, 0, 2048);
    in_valid = 1'b1;
    cycle();
    check("bp_head_stable", out_instr, held);
    out_ready = 1'b1;
    cycle();
    check("bp_enc_before_third", 32'(enc_count), 32'd2);
    cycle();
    in_valid = 1'b0;
    check("bp_enc_after_third", 32'(enc_count), 32'd3);
    repeat (3) cycle();

    // Reset with a full, stalled FIFO.
    out_ready = 1'b0;
    send(0, 1, 2, 3, 0, 32, 0);
    send(6, 9, 10, 0, 2, 0, -1);
    check("mid_full", 32'(in_ready), 32'd0);
    do_reset();

    // err_count saturation with invalid-type bundles streaming through.
    out_ready = 1'b1;
    set_fields(7, 31, 31, 31, 7, 127, 0);
    in_valid = 1'b1;
    repeat (300) cycle();
    in_valid = 1'b0;
    check("sat_err_count", 32'(err_count), 32'd255);
    check("sat_enc_wrap", 32'(enc_count), 32'(300 % 16));
    cycle();

    // enc_count wrap after exactly 2^CNT_W accepts.
    do_reset();
    set_fields(0, 1, 1, 1, 0, 0, 0);
    in_valid = 1'b1;
    repeat (16) cycle();
    in_valid = 1'b0;
    check("wrap_enc_count", 32'(enc_count), 32'd0);
    cycle();

    // Randomized traffic with random backpressure.
    do_reset();
    repeat (600) begin
      set_fields(int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 127)), rand_imm());
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the decode-stage immediate sign-extension path. Accepts instruction fields plus a full 32-bit immediate, range-checks the immediate for the selected format, and packs a 32-bit RV32I instruction word (R/I/S/B/U/J/load).
- Output goes through a small FIFO with valid/ready on both sides.
- Used as a stimulus generator for decode benches and by the on-chip test-program loader.

Parameters:
- DEPTH, 2, output FIFO entries (power of two, at least 2).
- CNT_W, 16, width of the encoded-instruction counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- in_type  in  3  0=R, 1=I (opcode 0010011), 2=S, 3=B, 4=U (LUI), 5=J, 6=L (load, opcode 0000011), 7=invalid
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7, used by R only
- in_imm  in  32  signed immediate; for U it is the full upper value
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_instr  out  32  packed instruction
- out_err  out  1  head was range-checked as bad
- enc_count  out  CNT_W  bundles accepted, wraps
- err_count  out  8  bundles flagged bad, saturates at 255

Behaviour:
- Reset, synchronous: FIFO empty, out_valid=0, out_instr=0, out_err=0, enc_count=0, err_count=0. in_ready=1 in the first cycle after reset.
- Accept when in_valid & in_ready.
- in_ready = (fifo_count < DEPTH). No combinational path from out_ready to in_ready.
- Latency: a bundle accepted on edge N appears at the FIFO head (out_valid=1) after edge N when the FIFO was empty.
- out_instr/out_err are registered and held stable while out_valid & ~out_ready.
- Pop on out_valid & out_ready. Push and pop in the same cycle: count unchanged, order preserved. This is legal when full only if in_ready was already high, which it cannot be while full.
- Packing:
  - R: funct7, rs2, rs1, funct3, rd, 0110011.
  - I and L: imm[11:0], rs1, funct3, rd, opcode.
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0], 0100011.
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 1100011.
  - U: imm[31:12], rd, 0110111.
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111.
- Range rules (err=1 if violated):
  - I, S, L: -2048 <= imm <= 2047.
  - B: -4096 <= imm <= 4094 and imm[0]=0.
  - J: -1048576 <= imm <= 1048574 and imm[0]=0.
  - U: imm[11:0]=0.
  - R: imm ignored, never errors.
  - type 7: always errors.
- On error: the immediate field bits are forced to 0, other fields are packed normally, and out_err=1. For type 7, out_instr=0.
- enc_count increments on every accept, including errored ones, and wraps at 2^CNT_W.
- err_count increments on an errored accept and holds at 255.
- Reset mid-operation discards FIFO contents, even if out_valid was high and out_ready was low.

Test Plan:
- After rst, I-type rd=1, rs1=0, funct3=0, imm=-5, out_ready=1 -> one cycle later out_instr=0xFFB00093, out_err=0, enc_count=1.
- S-type rs1=1, rs2=2, funct3=2, imm=8 -> out_instr=0x0020A423. B-type rs1=0, rs2=0, funct3=0, imm=-4 -> out_instr=0xFE000EE3.
- Range errors:
  - I-type rd=1, imm=2048 -> out_instr=0x00000093, out_err=1, err_count=1.
  - B-type imm=3 -> out_err=1.
  - U-type imm=0x12345000, rd=5 -> out_instr=0x123452B7, out_err=0.
- Backpressure: out_ready=0, three bundles offered back-to-back -> first two accepted, in_ready=0 after the second, head stable. Raise out_ready -> in-order drain, third accepted the cycle after the first pop, enc_count=3.
- Reset mid-flow: FIFO holding 2 entries, out_ready=0, assert rst for one cycle -> next cycle out_valid=0, in_ready=1, counters 0.
- Saturation and wrap: 300 errored type-7 bundles -> err_count=255, every out_instr=0. Overflow enc_count with CNT_W=4 -> wraps to 0 after 16 accepts.
